instr_mem_loader: RTL and testbench

- Parametrised, run-time loadable successor to the fixed-content instruction ROM feeding the MIPS fetch stage.
- Holds up to 2**ADDR_W 32-bit instruction words in an internal array. The array is written by a byte-serial load port (e.g. from the UART receiver) and read by the CPU through a registered fetch port.
- Unprogrammed or out-of-range words read as a jump-to-0 instruction, so the CPU spins safely at reset vector 0.

---
 rtl/instr_mem_pkg.sv | 18 +
 rtl/load_word_assembler.sv | 46 ++++
 rtl/instr_mem_loader.sv | 150 +++++++++++++++
 tb/tb_instr_mem_loader.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_pkg.sv
// Shared definitions for the run-time loadable instruction memory.
//   DEFAULT_INSTR  : jump-to-0 word returned for unprogrammed locations
//   state_t        : loader FSM states
//   BYTE_CNT_W     : width of the byte-within-word counter
package instr_mem_pkg;

  // MIPS "j 0": a CPU fetching unprogrammed space spins at the reset vector.
  localparam logic [31:0] DEFAULT_INSTR = 32'h0800_0000;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_CNT_W     = 2;

  typedef enum logic {
    RUN  = 1'b0,
    LOAD = 1'b1
  } state_t;

endpackage

// File: rtl/load_word_assembler.sv
// Collects big-endian program bytes into 32-bit words.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   clear      : drop any partially assembled word
//   byte_vld   : byte_in is to be consumed this cycle
//   byte_in    : program byte (first byte of a word is the MSB)
//   byte_cnt   : bytes already held for the current word (0..3)
//   word_vld   : combinational strobe, the 4th byte is arriving now
//   word       : assembled word, meaningful while word_vld is high
module load_word_assembler
  import instr_mem_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  byte_vld,
  input  logic [7:0]            byte_in,
  output logic [BYTE_CNT_W-1:0] byte_cnt,
  output logic                  word_vld,
  output logic [31:0]           word
);

  logic [23:0] shift_q;

  // The counter wraps 3 -> 0 on the word-completing byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_cnt <= '0;
    end else if (clear) begin
      byte_cnt <= '0;
    end else if (byte_vld) begin
      byte_cnt <= byte_cnt + 1'b1;
    end
  end

  // Data path carries no reset: byte_cnt decides when its contents matter.
  always_ff @(posedge clk) begin
    if (byte_vld) begin
      shift_q <= {shift_q[15:0], byte_in};
    end
  end

  assign word_vld = byte_vld && (byte_cnt == BYTE_CNT_W'(BYTES_PER_WORD - 1));
  assign word     = {shift_q, byte_in};

endmodule

// File: rtl/instr_mem_loader.sv
// Run-time loadable instruction memory for the MIPS fetch stage.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   fetch_addr  : CPU byte address, word index = fetch_addr[ADDR_W+1:2]
//   fetch_data  : registered instruction word (one-cycle latency)
//   load_start  : pulse, begin (or restart) a program load
//   load_valid  : load_byte is valid this cycle
//   load_byte   : program byte, big-endian within each word
//   load_end    : pulse, program transfer finished
//   loading     : high while a load is in progress, CPU must stall
//   load_error  : sticky, partial last word or overflow
//   word_count  : number of complete words programmed
module instr_mem_loader
  import instr_mem_pkg::*;
#(
  parameter int          ADDR_W       = 6,
  parameter logic [31:0] DEFAULT_WORD = DEFAULT_INSTR
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     fetch_addr,
  output logic [31:0]     fetch_data,
  input  logic            load_start,
  input  logic            load_valid,
  input  logic [7:0]      load_byte,
  input  logic            load_end,
  output logic            loading,
  output logic            load_error,
  output logic [ADDR_W:0] word_count
);

  localparam int DEPTH = 1 << ADDR_W;

  state_t                state;
  state_t                state_next;
  logic                  restart;
  logic                  accept;
  logic                  overflow;
  logic                  finish;
  logic                  partial_end;
  logic                  full;
  logic [ADDR_W:0]       wr_ptr;
  logic [BYTE_CNT_W-1:0] byte_cnt;
  logic                  word_vld;
  logic [31:0]           word;
  logic [31:0]           mem [DEPTH];
  logic [ADDR_W-1:0]     fetch_idx;
  logic                  unused_addr_bits;

  // wr_ptr reaches DEPTH once every location has been written.
  assign full = wr_ptr[ADDR_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // load_start takes priority over everything else in either state, so a
  // byte or load_end arriving alongside it is dropped.
  always_comb begin
    state_next = state;
    restart    = 1'b0;
    accept     = 1'b0;
    overflow   = 1'b0;
    finish     = 1'b0;
    unique case (state)
      RUN: begin
        if (load_start) begin
          state_next = LOAD;
          restart    = 1'b1;
        end
      end
      LOAD: begin
        if (load_start) begin
          restart = 1'b1;
        end else begin
          accept   = load_valid && !full;
          overflow = load_valid && full;
          if (load_end) begin
            state_next = RUN;
            finish     = 1'b1;
          end
        end
      end
      default: state_next = RUN;
    endcase
  end

  // A byte arriving with load_end counts first; the transfer is only partial
  // if that byte does not complete a word, or if bytes were already pending.
  assign partial_end = accept ? !word_vld : (byte_cnt != '0);

  load_word_assembler u_asm (
    .clk      (clk),
    .reset    (reset),
    .clear    (restart || finish),
    .byte_vld (accept),
    .byte_in  (load_byte),
    .byte_cnt (byte_cnt),
    .word_vld (word_vld),
    .word     (word)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      load_error <= 1'b0;
    end else begin
      if (restart) begin
        wr_ptr <= '0;
      end else if (word_vld) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (restart) begin
        load_error <= 1'b0;
      end else if (overflow || (finish && partial_end)) begin
        load_error <= 1'b1;
      end
    end
  end

  // word_vld implies !full, so the truncated pointer is always in range.
  always_ff @(posedge clk) begin
    if (word_vld) begin
      mem[wr_ptr[ADDR_W-1:0]] <= word;
    end
  end

  assign loading    = (state == LOAD);
  assign word_count = wr_ptr;

  // Fetch stage: the array read here sees the pre-edge contents, giving
  // read-before-write on a same-cycle write to the same word.
  assign fetch_idx        = fetch_addr[ADDR_W+1:2];
  assign unused_addr_bits = ^{fetch_addr[31:ADDR_W+2], fetch_addr[1:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_data <= DEFAULT_WORD;
    end else if (loading || ({1'b0, fetch_idx} >= wr_ptr)) begin
      fetch_data <= DEFAULT_WORD;
    end else begin
      fetch_data <= mem[fetch_idx];
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: a 64-word and a 4-word instance
// share one stimulus stream and are compared against a byte/word list model.
module tb_instr_mem_loader;

  localparam logic [31:0] DEF = 32'h0800_0000;

  logic        clk;
  logic        reset;
  logic [31:0] fetch_addr;
  logic        load_start;
  logic        load_valid;
  logic [7:0]  load_byte;
  logic        load_end;

  logic [31:0] fd0, fd1;
  logic        ld0, ld1, er0, er1;
  logic [6:0]  wc0;
  logic [2:0]  wc1;

  int total = 0;
  int bad   = 0;

  instr_mem_loader #(.ADDR_W(6)) dut_big (
    .clk(clk), .reset(reset), .fetch_addr(fetch_addr), .fetch_data(fd0),
    .load_start(load_start), .load_valid(load_valid), .load_byte(load_byte),
    .load_end(load_end), .loading(ld0), .load_error(er0), .word_count(wc0)
  );

  instr_mem_loader #(.ADDR_W(2)) dut_small (
    .clk(clk), .reset(reset), .fetch_addr(fetch_addr), .fetch_data(fd1),
    .load_start(load_start), .load_valid(load_valid), .load_byte(load_byte),
    .load_end(load_end), .loading(ld1), .load_error(er1), .word_count(wc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: per instance, the list of complete words of the current
  // program, the bytes of the pending word, and the load/error flags.
  int          depth   [2] = '{64, 4};
  logic [31:0] prog    [2][64];
  logic [7:0]  part    [2][4];
  int          nwords  [2];
  int          npart   [2];
  bit          inload  [2];
  bit          err     [2];
  logic [31:0] exp_fetch [2];

  function automatic logic [31:0] model_fetch(input int k, input logic [31:0] a);
    int idx;
    idx = (k == 0) ? int'(a[7:2]) : int'(a[3:2]);
    if (inload[k]) return DEF;
    if (idx < nwords[k]) return prog[k][idx];
    return DEF;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      nwords[k] = 0; npart[k] = 0; inload[k] = 0; err[k] = 0;
      exp_fetch[k] = DEF;
    end
  endfunction

  function automatic void model_edge(input int k, input logic s, input logic v,
                                     input logic [7:0] b, input logic e);
    if (s) begin
      inload[k] = 1; nwords[k] = 0; npart[k] = 0; err[k] = 0;
    end else if (inload[k]) begin
      if (v) begin
        if (nwords[k] == depth[k]) begin
          err[k] = 1;
        end else begin
          part[k][npart[k]] = b;
          npart[k]++;
          if (npart[k] == 4) begin
            prog[k][nwords[k]] = {part[k][0], part[k][1], part[k][2], part[k][3]};
            nwords[k]++;
            npart[k] = 0;
          end
        end
      end
      if (e) begin
        if (npart[k] != 0) err[k] = 1;
        npart[k]  = 0;
        inload[k] = 0;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("fetch_big",    fd0,              exp_fetch[0]);
    chk("count_big",    32'(wc0),         32'(nwords[0]));
    chk("loading_big",  32'(ld0),         32'(inload[0]));
    chk("error_big",    32'(er0),         32'(err[0]));
    chk("fetch_small",  fd1,              exp_fetch[1]);
    chk("count_small",  32'(wc1),         32'(nwords[1]));
    chk("loading_small",32'(ld1),         32'(inload[1]));
    chk("error_small",  32'(er1),         32'(err[1]));
  endtask

  // One clock: drive inputs, advance the model at the edge, check #1 later.
  task automatic step(input logic s, input logic v, input logic [7:0] b,
                      input logic e, input logic [31:0] a);
    load_start = s; load_valid = v; load_byte = b; load_end = e; fetch_addr = a;
    for (int k = 0; k < 2; k++) exp_fetch[k] = model_fetch(k, a);
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_edge(k, s, v, b, e);
    #1;
    check_all();
  endtask

  task automatic idle(input logic [31:0] a);
    step(1'b0, 1'b0, 8'h00, 1'b0, a);
  endtask

  // Asynchronous reset between edges; outputs must respond without a clock.
  task automatic async_reset();
    load_start = 0; load_valid = 0; load_end = 0;
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all();
    reset = 1'b0;
    idle(32'h0);
  endtask

  logic [7:0] dir_bytes [8] = '{8'h20, 8'h08, 8'h00, 8'h40, 8'hAC, 8'h08, 8'h00, 8'h00};

  initial begin
    int  nb;
    bit  ended;
    reset = 1'b1; fetch_addr = '0; load_start = 0; load_valid = 0;
    load_byte = '0; load_end = 0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    check_all();
    reset = 1'b0;

    // Empty memory reads the jump-to-0 word everywhere.
    idle(32'h0); idle(32'h4); idle(32'hFC);
    chk("reset_fetch_fc", fd0, DEF);
    chk("reset_count", 32'(wc0), 32'd0);

    // Two-word program.
    step(1, 0, 8'h00, 0, 32'h0);
    for (int i = 0; i < 8; i++) step(0, 1, dir_bytes[i], 0, 32'h0);
    step(0, 0, 8'h00, 1, 32'h0);
    idle(32'h0); chk("dir_word0", fd0, 32'h2008_0040);
    idle(32'h4); chk("dir_word1", fd0, 32'hAC08_0000);
    idle(32'h8); chk("dir_word2", fd0, DEF);
    chk("dir_count", 32'(wc0), 32'd2);
    chk("dir_error", 32'(er0), 32'd0);

    // Six bytes: one word kept, partial word flagged.
    step(1, 0, 8'h00, 0, 32'h0);
    for (int i = 0; i < 6; i++) step(0, 1, 8'(8'h11 * (i + 1)), 0, 32'h0);
    step(0, 0, 8'h00, 1, 32'h0);
    idle(32'h4);
    chk("partial_count", 32'(wc0), 32'd1);
    chk("partial_error", 32'(er0), 32'd1);
    chk("partial_fetch4", fd0, DEF);

    // Five words: the 4-word instance overflows on byte 17.
    step(1, 0, 8'h00, 0, 32'h0);
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 8'(i + 8'h30), 0, 32'h0);
      if (i == 15) chk("ovf_not_yet", 32'(er1), 32'd0);
      if (i == 16) chk("ovf_byte17", 32'(er1), 32'd1);
    end
    step(0, 0, 8'h00, 1, 32'h0);
    idle(32'h10);
    chk("alias_small", fd1, 32'h3031_3233);
    chk("no_alias_big", fd0, 32'h4041_4243);
    chk("ovf_count_small", 32'(wc1), 32'd4);

    // Reset after three words, then a clean reload.
    step(1, 0, 8'h00, 0, 32'h0);
    for (int i = 0; i < 12; i++) step(0, 1, 8'($urandom), 0, 32'h0);
    async_reset();
    idle(32'h0); idle(32'h4);
    chk("rst_mid_fetch", fd0, DEF);
    step(1, 0, 8'h00, 0, 32'h0);
    for (int i = 0; i < 8; i++) step(0, 1, 8'($urandom), 0, 32'h0);
    step(0, 0, 8'h00, 1, 32'h0);
    idle(32'h0); idle(32'h4);

    // Last byte together with load_end, then start+end in LOAD.
    step(1, 0, 8'h00, 0, 32'h0);
    for (int i = 0; i < 7; i++) step(0, 1, 8'(8'hA0 + i), 0, 32'h0);
    step(0, 1, 8'hA7, 1, 32'h0);
    chk("same_cycle_error", 32'(er0), 32'd0);
    chk("same_cycle_count", 32'(wc0), 32'd2);
    idle(32'h4); chk("same_cycle_word1", fd0, 32'hA4A5_A6A7);
    step(1, 0, 8'h00, 0, 32'h0);
    step(1, 0, 8'h00, 1, 32'h0);
    chk("start_wins", 32'(ld0), 32'd1);
    step(0, 0, 8'h00, 1, 32'h0);

    // Randomised loads, gaps, restarts, stray RUN-state inputs and resets.
    for (int it = 0; it < 50; it++) begin
      nb    = ($urandom_range(0, 7) == 0) ? $urandom_range(250, 270) : $urandom_range(0, 40);
      ended = 0;
      step(1, 0, 8'h00, 0, $urandom);
      for (int i = 0; i < nb; i++) begin
        while ($urandom_range(0, 3) == 0) step(0, 0, 8'($urandom), 0, $urandom);
        if (i == nb - 1 && $urandom_range(0, 1) == 1) begin
          step(0, 1, 8'($urandom), 1, $urandom);
          ended = 1;
        end else begin
          step(0, 1, 8'($urandom), 0, $urandom);
        end
        if (!ended && $urandom_range(0, 199) == 0) step(1, 0, 8'h00, 0, $urandom);
      end
      if ($urandom_range(0, 15) == 0) async_reset();
      if (!ended) step(0, 0, 8'h00, 1, $urandom);
      for (int j = 0; j < 12; j++)
        step(0, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) == 0), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard bound so the run always ends.
  initial begin
    #900000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
